// File: rtl/iterative_operations.sv
// rtl/iterative_operations.sv - multi-cycle iterative arithmetic engine (accumulate, double, multiply, gcd)
module iterative_operations #(
    parameter int REGISTER_WIDTH = 32,
    parameter int ITER_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic                      abort,
    input  logic [7:0]                operation_id,
    input  logic [REGISTER_WIDTH-1:0] input_var_0,
    input  logic [REGISTER_WIDTH-1:0] input_var_1,
    input  logic [REGISTER_WIDTH-1:0] input_var_2,
    output logic [REGISTER_WIDTH-1:0] results,
    output logic                      finished,
    output logic                      busy,
    output logic                      error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_ACCUM  = 8'd0;
    localparam logic [7:0] OP_DOUBLE = 8'd1;
    localparam logic [7:0] OP_MULT   = 8'd2;
    localparam logic [7:0] OP_GCD    = 8'd3;

    localparam logic [REGISTER_WIDTH-1:0] ZERO       = '0;
    localparam logic [REGISTER_WIDTH-1:0] ONE        = REGISTER_WIDTH'(1);
    localparam logic [REGISTER_WIDTH-1:0] MULT_STEPS = REGISTER_WIDTH'(REGISTER_WIDTH);
    // Keeps only the low ITER_WIDTH bits of the iteration-count operand.
    localparam logic [REGISTER_WIDTH-1:0] ITER_MASK  =
        {REGISTER_WIDTH{1'b1}} >> (REGISTER_WIDTH - ITER_WIDTH);

    state_t                    state_q, state_d;
    logic [7:0]                op_q, op_d;
    logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
    logic [REGISTER_WIDTH-1:0] a_q, a_d;
    logic [REGISTER_WIDTH-1:0] b_q, b_d;
    logic [REGISTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [REGISTER_WIDTH-1:0] results_q, results_d;
    logic                      error_q, error_d;

    logic                      last_step;
    logic                      early_done;
    logic [REGISTER_WIDTH-1:0] n_count;
    logic [REGISTER_WIDTH-1:0] sum;
    logic [REGISTER_WIDTH-1:0] mult_step;

    // State and datapath registers; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 8'd0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            results_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            results_q <= results_d;
            error_q   <= error_d;
        end
    end

    // Operand capture on go, one iteration step per RUN cycle, result write on the final step.
    always_comb begin
        op_d       = op_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        results_d  = results_q;
        error_d    = error_q;
        last_step  = 1'b0;
        early_done = 1'b0;
        n_count    = input_var_2 & ITER_MASK;
        sum        = acc_q + a_q;
        mult_step  = b_q[0] ? sum : acc_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    op_d    = operation_id;
                    a_d     = input_var_0;
                    b_d     = input_var_1;
                    cnt_d   = n_count;
                    error_d = 1'b0;
                    case (operation_id)
                        OP_ACCUM: begin
                            acc_d = input_var_1;
                            if (n_count == ZERO) begin
                                early_done = 1'b1;
                                results_d  = input_var_1;
                            end
                        end
                        OP_DOUBLE: begin
                            acc_d = input_var_0;
                            if (n_count == ZERO) begin
                                early_done = 1'b1;
                                results_d  = input_var_0;
                            end
                        end
                        OP_MULT: begin
                            acc_d = '0;
                            cnt_d = MULT_STEPS;
                        end
                        OP_GCD: begin
                            acc_d = '0;
                        end
                        default: begin
                            early_done = 1'b1;
                            results_d  = '0;
                            error_d    = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                // An abort in the same cycle suppresses the step and any result write.
                if (!abort) begin
                    case (op_q)
                        OP_ACCUM: begin
                            acc_d = sum;
                            cnt_d = cnt_q - ONE;
                            if (cnt_q == ONE) begin
                                last_step = 1'b1;
                                results_d = sum;
                            end
                        end
                        OP_DOUBLE: begin
                            acc_d = acc_q << 1;
                            cnt_d = cnt_q - ONE;
                            if (cnt_q == ONE) begin
                                last_step = 1'b1;
                                results_d = acc_q << 1;
                            end
                        end
                        OP_MULT: begin
                            acc_d = mult_step;
                            a_d   = a_q << 1;
                            b_d   = b_q >> 1;
                            cnt_d = cnt_q - ONE;
                            if (cnt_q == ONE) begin
                                last_step = 1'b1;
                                results_d = mult_step;
                            end
                        end
                        OP_GCD: begin
                            if (b_q == ZERO) begin
                                last_step = 1'b1;
                                results_d = a_q;
                            end else if (a_q >= b_q) begin
                                a_d = a_q - b_q;
                            end else begin
                                a_d = b_q;
                                b_d = a_q;
                            end
                        end
                        default: begin
                            last_step = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

    // Next-state selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = early_done ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status and result outputs decoded from registered state.
    always_comb begin
        results  = results_q;
        error    = error_q;
        busy     = (state_q != IDLE);
        finished = (state_q == DONE);
    end

endmodule

// File: doc/iterative_operations.md
ITERATIVE_OPERATIONS -- requirements
Module: iterative_operations

Interface
REQ-001 Parameter REGISTER_WIDTH, default 32: operand and result width in bits, minimum 8.
REQ-002 Parameter ITER_WIDTH, default 8: iteration-count width in bits, at most REGISTER_WIDTH.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  start request, sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a running operation.
REQ-008 operation_id  input  8  operation select, latched on an accepted go.
REQ-009 input_var_0  input  REGISTER_WIDTH  operand A.
REQ-010 input_var_1  input  REGISTER_WIDTH  operand B.
REQ-011 input_var_2  input  REGISTER_WIDTH  iteration count N in bits [ITER_WIDTH-1:0]; upper bits ignored.
REQ-012 results  output  REGISTER_WIDTH  registered result.
REQ-013 finished  output  1  one-cycle completion pulse.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 error  output  1  unsupported operation_id flag.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL leave DONE for IDLE unconditionally after one cycle.
REQ-017 A go sampled high in IDLE SHALL latch all inputs and clear error.
  - Next state is RUN.
  - For ACCUM or DOUBLE with N=0, next state is DONE.
  - For an unsupported operation_id, next state is DONE.
REQ-018 A go sampled in RUN or DONE SHALL be ignored, with no queuing.
REQ-019 RUN SHALL perform exactly one iteration step per clock.
REQ-020 The final step SHALL write results and enter DONE.
REQ-021 finished SHALL be high exactly during the DONE cycle.
REQ-022 results SHALL hold its value until the next completion.
REQ-023 Operation 0, ACCUM: acc=B, then N steps of acc=acc+A, modulo 2^REGISTER_WIDTH.
  - finished SHALL be high in the cycle after edge t+N, where t is the go-accepting edge.
REQ-024 Operation 1, DOUBLE: acc=A, then N steps of acc=acc<<1 with zero fill.
  - Latency is as for ACCUM.
REQ-025 Operation 2, MULT: unsigned shift-add multiply, one multiplier bit per step.
  - REGISTER_WIDTH steps; results holds the low REGISTER_WIDTH bits of A*B.
REQ-026 Operation 3, GCD: subtraction Euclid, one action per RUN cycle:
  - if b==0, finish with results=a;
  - else if a>=b, a=a-b;
  - else swap a and b.
REQ-027 GCD boundaries: gcd(A,0)=A; gcd(0,B)=B; gcd(0,0)=0.
REQ-028 Any other operation_id SHALL complete with results=0 and error=1.
  - DONE follows the go cycle.
  - error holds until the next accepted go.
REQ-029 abort high in RUN SHALL return the FSM to IDLE on the next edge.
  - No finished pulse is produced, and results is unchanged.
  - abort SHALL be ignored in IDLE and DONE.
REQ-030 abort SHALL take priority over a final step in the same cycle.
REQ-031 All arithmetic SHALL be unsigned; overflow SHALL wrap silently.

Reset
REQ-032 reset high SHALL immediately, without waiting for clk, force the following, including mid-operation:
  - state=IDLE, results=0, finished=0, busy=0, error=0;
  - all internal counters and operand registers cleared.
REQ-033 The first go SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 ACCUM, W=32: A=5, B=7, N=10 -> results=57; finished pulses once, 10 cycles after go; busy high for 11 cycles.
REQ-035 DOUBLE: A=3, N=4 -> results=48. DOUBLE: A=0x80000000, N=1 -> results=0 (wrap). ACCUM with N=0, B=9 -> results=9, finished one cycle after go.
REQ-036 MULT: A=0x0001_0001, B=0x0000_FFFF -> results=0xFFFF_FFFF after 32 steps. GCD: (12,8) -> 4; (0,0) -> 0; (17,0) -> 17.
REQ-037 operation_id=0xAA -> results=0, error=1, finished one cycle after go; the following valid go clears error.
REQ-038 ACCUM with N=200 under the sequence below -> busy=0 and finished never pulses:
  - go while busy, which SHALL be ignored;
  - abort at step 50;
  - then reset asserted mid-GCD.
  - All outputs read 0 after reset.
